mem_access_unit: RTL and testbench

Pipeline-side initiator for the word-organised data memory. Accepts byte/halfword/word load and store requests from the MEM stage and drives the memory's `address`/`dataWrite`/`writeMem`/`readMem` interface, with `dataRead` returned. Sub-word loads are extracted and sign- or zero-extended; sub-word stores use a two-cycle read-modify-write. Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/mem_access_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_lane_align.sv | 27 ++
 rtl/mem_access_unit.sv | 100 ++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size encodings, FSM states and defaults for mem_access_unit
// Contents: SIZE_* request size codes, memState FSM encoding, DEFAULT_MEM_WORDS.
package mem_access_pkg;
  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;
  localparam int DEFAULT_MEM_WORDS = 128;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } memState;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if / mem_bus_if: request/response channel and memory bus
// mem_access_unit_if: master = MEM stage (drives req*), slave = unit (drives reqReady, resp*).
// mem_bus_if: master = unit (drives address/data/enables), slave = memory (drives memDataRead).
interface mem_access_unit_if #(parameter int BITS = 32);
  logic reqValid;
  logic reqReady;
  logic reqWrite;
  logic [1:0] reqSize;
  logic reqSigned;
  logic [BITS-1:0] reqAddress;
  logic [BITS-1:0] reqData;
  logic respValid;
  logic [BITS-1:0] respData;
  logic respError;
  modport master(output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
                 input reqReady, respValid, respData, respError);
  modport slave(input reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
                output reqReady, respValid, respData, respError);
endinterface

interface mem_bus_if #(parameter int BITS = 32);
  logic [BITS-1:0] memAddress;
  logic [BITS-1:0] memDataWrite;
  logic [BITS-1:0] memDataRead;
  logic memRead;
  logic memWrite;
  modport master(output memAddress, memDataWrite, memRead, memWrite, input memDataRead);
  modport slave(input memAddress, memDataWrite, memRead, memWrite, output memDataRead);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian sub-word load extraction/extension and store merge
// Inputs: addrLow (addr[1:0]), size, isSigned, readWord (load source), mergeWord (RMW base),
// storeData (right-aligned). Outputs: loadData (extended lane), mergedWord (word to write).
module mem_lane_align import mem_access_pkg::*; #(parameter int BITS = 32) (
  input  logic [1:0]      addrLow,
  input  logic [1:0]      size,
  input  logic            isSigned,
  input  logic [BITS-1:0] readWord,
  input  logic [BITS-1:0] mergeWord,
  input  logic [BITS-1:0] storeData,
  output logic [BITS-1:0] loadData,
  output logic [BITS-1:0] mergedWord
);
  logic [4:0] shamt;
  logic [BITS-1:0] shifted;
  logic [BITS-1:0] laneMask;
  // Words are always aligned, so the byte-lane shift collapses to zero for them.
  always_comb begin
    shamt = size == SIZE_HALF ? {addrLow[1], 4'b0} : {addrLow, 3'b0};
    shifted = readWord >> shamt;
    laneMask = size == SIZE_BYTE ? BITS'(8'hFF) : size == SIZE_HALF ? BITS'(16'hFFFF) : '1;
    loadData = size == SIZE_BYTE ? {{(BITS-8){isSigned & shifted[7]}}, shifted[7:0]}
             : size == SIZE_HALF ? {{(BITS-16){isSigned & shifted[15]}}, shifted[15:0]}
             : shifted;
    mergedWord = (mergeWord & ~(laneMask << shamt)) | ((storeData & laneMask) << shamt);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for byte/half/word loads and stores to word memory
// Ports: clk, resetN (async active-low), req (mem_access_unit_if.slave: request/response
// handshake), mem (mem_bus_if.master: memAddress/memDataWrite/memRead/memWrite/memDataRead).
module mem_access_unit import mem_access_pkg::*; #(
  parameter int BITS = 32,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input logic clk,
  input logic resetN,
  mem_access_unit_if.slave req,
  mem_bus_if.master mem
);
  memState state;
  logic [1:0] sizeReg;
  logic [1:0] addrLow;
  logic signedReg;
  logic [BITS-1:0] addrReg;
  logic [BITS-1:0] dataReg;
  logic [BITS-1:0] mergeReg;
  logic [BITS-1:0] respDataReg;
  logic respErrorReg;
  logic reqBad;
  logic [BITS-1:0] loadData;
  logic [BITS-1:0] mergedWord;

  always_comb begin
    reqBad = req.reqSize == SIZE_ILLEGAL
          || (req.reqSize == SIZE_HALF && req.reqAddress[0])
          || (req.reqSize == SIZE_WORD && req.reqAddress[1:0] != 2'b00)
          || (req.reqAddress >> 2) >= BITS'(MEM_WORDS);
  end

  mem_lane_align #(.BITS(BITS)) align (
    .addrLow(addrLow),
    .size(sizeReg),
    .isSigned(signedReg),
    .readWord(mem.memDataRead),
    .mergeWord(mergeReg),
    .storeData(dataReg),
    .loadData(loadData),
    .mergedWord(mergedWord)
  );

  // Enables decode from state alone so an async reset drops them immediately.
  assign req.reqReady = state == IDLE;
  assign req.respValid = state == RESP;
  assign req.respData = respDataReg;
  assign req.respError = respErrorReg;
  assign mem.memAddress = addrReg;
  assign mem.memRead = state == LOAD || state == RMW_RD;
  assign mem.memWrite = state == STORE || state == RMW_WR;
  assign mem.memDataWrite = state == STORE ? dataReg : state == RMW_WR ? mergedWord : '0;

  // respData/respError only change on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      sizeReg <= '0;
      addrLow <= '0;
      signedReg <= 1'b0;
      addrReg <= '0;
      dataReg <= '0;
      mergeReg <= '0;
      respDataReg <= '0;
      respErrorReg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req.reqValid) begin
          sizeReg <= req.reqSize;
          addrLow <= req.reqAddress[1:0];
          signedReg <= req.reqSigned;
          addrReg <= {req.reqAddress[BITS-1:2], 2'b00};
          dataReg <= req.reqData;
          if (reqBad) begin
            respDataReg <= '0;
            respErrorReg <= 1'b1;
            state <= RESP;
          end else begin
            state <= !req.reqWrite ? LOAD : req.reqSize == SIZE_WORD ? STORE : RMW_RD;
          end
        end
        LOAD: begin
          respDataReg <= loadData;
          respErrorReg <= 1'b0;
          state <= RESP;
        end
        STORE, RMW_WR: begin
          respDataReg <= '0;
          respErrorReg <= 1'b0;
          state <= RESP;
        end
        RMW_RD: begin
          mergeReg <= mem.memDataRead;
          state <= RMW_WR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a 128-word memory model
module tb_mem_access_unit;
  import mem_access_pkg::*;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.BITS(32)) rq();
  mem_bus_if #(.BITS(32)) mb();

  mem_access_unit #(.BITS(32), .MEM_WORDS(128)) dut (
    .clk(clk),
    .resetN(resetN),
    .req(rq),
    .mem(mb)
  );

  logic [31:0] memArr [128] = '{default: 32'h0};
  assign mb.memDataRead = memArr[mb.memAddress[8:2]];

  int cyc = 0;
  int rdCount = 0;
  int wrCount = 0;
  int accepts = 0;
  logic [31:0] lastWr = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mb.memWrite) begin
      memArr[mb.memAddress[8:2]] <= mb.memDataWrite;
      wrCount <= wrCount + 1;
      lastWr <= mb.memDataWrite;
    end
    if (mb.memRead) rdCount <= rdCount + 1;
    if (rq.reqValid && rq.reqReady) accepts <= accepts + 1;
  end

  typedef struct {
    logic [31:0] data;
    logic err;
    int due;
  } expT;
  expT sb[$];
  int tests = 0;
  int fails = 0;

  // Called at a negedge; returns at the negedge one cycle after the accept edge.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] expData, input logic expErr, input int lat);
    int n = 0;
    rq.reqWrite = wr;
    rq.reqSize = size;
    rq.reqSigned = sgn;
    rq.reqAddress = addr;
    rq.reqData = data;
    rq.reqValid = 1'b1;
    while (!rq.reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!rq.reqReady) begin
      fails++;
      $display("FAIL accept addr=%h: reqReady=%b required 1", addr, rq.reqReady);
    end else sb.push_back('{expData, expErr, cyc + lat});
    @(negedge clk);
  endtask

  task automatic waitResp(input string name);
    int n = 0;
    expT e;
    while (!rq.respValid && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!rq.respValid) begin
      fails++;
      $display("FAIL %s: respValid=0 required 1 within 10 cycles", name);
    end else if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      tests++;
      if (rq.respData !== e.data) begin
        fails++;
        $display("FAIL %s data: got %h required %h", name, rq.respData, e.data);
      end
      tests++;
      if (rq.respError !== e.err) begin
        fails++;
        $display("FAIL %s error: got %b required %b", name, rq.respError, e.err);
      end
      tests++;
      if (cyc !== e.due) begin
        fails++;
        $display("FAIL %s latency: got cycle %0d required %0d", name, cyc, e.due);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({rq.reqReady, rq.respValid, rq.respError, mb.memRead, mb.memWrite} !== 5'b10000) begin
      fails++;
      $display("FAIL reset flags: got %b required 10000",
               {rq.reqReady, rq.respValid, rq.respError, mb.memRead, mb.memWrite});
    end
    tests++;
    if ({rq.respData, mb.memAddress, mb.memDataWrite} !== 96'h0) begin
      fails++;
      $display("FAIL reset data: got %h %h %h required 0", rq.respData, mb.memAddress, mb.memDataWrite);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int r0;
    int w0;
    issue(1, SIZE_WORD, 0, 32'h10, 32'h8899AABB, 32'h0, 0, 2);
    waitResp("sw 0x10");
    issue(1, SIZE_WORD, 0, 32'h1FC, 32'hDEADBEEF, 32'h0, 0, 2);
    waitResp("sw 0x1FC");
    issue(0, SIZE_WORD, 0, 32'h1FC, 32'h0, 32'hDEADBEEF, 0, 2);
    waitResp("lw 0x1FC");
    r0 = rdCount;
    w0 = wrCount;
    issue(0, SIZE_WORD, 0, 32'h200, 32'h0, 32'h0, 1, 1);
    waitResp("lw 0x200 range");
    tests++;
    if (rdCount != r0 || wrCount != w0) begin
      fails++;
      $display("FAIL range enables: reads %0d writes %0d required 0 0", rdCount - r0, wrCount - w0);
    end
  endtask

  task automatic test_byte_load();
    issue(0, SIZE_BYTE, 1, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2);
    waitResp("lb 0x11");
    issue(0, SIZE_BYTE, 0, 32'h11, 32'h0, 32'h000000AA, 0, 2);
    waitResp("lbu 0x11");
    issue(0, SIZE_BYTE, 1, 32'h10, 32'h0, 32'hFFFFFFBB, 0, 2);
    waitResp("lb 0x10");
    issue(0, SIZE_BYTE, 0, 32'h13, 32'h0, 32'h00000088, 0, 2);
    waitResp("lbu 0x13");
    issue(0, SIZE_HALF, 1, 32'h12, 32'h0, 32'hFFFF8899, 0, 2);
    waitResp("lh 0x12");
    issue(0, SIZE_HALF, 0, 32'h10, 32'h0, 32'h0000AABB, 0, 2);
    waitResp("lhu 0x10");
    issue(0, SIZE_WORD, 1, 32'h10, 32'h0, 32'h8899AABB, 0, 2);
    waitResp("lw signed 0x10");
  endtask

  task automatic test_half_store();
    int w0;
    w0 = wrCount;
    issue(1, SIZE_HALF, 0, 32'h12, 32'hFFFF1234, 32'h0, 0, 3);
    waitResp("sh 0x12");
    tests++;
    if (wrCount - w0 != 1 || lastWr !== 32'h1234AABB) begin
      fails++;
      $display("FAIL sh write: got %0d writes data %h required 1 writes data 1234aabb", wrCount - w0, lastWr);
    end
    issue(1, SIZE_BYTE, 0, 32'h11, 32'hA55A, 32'h0, 0, 3);
    waitResp("sb 0x11");
    issue(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h12345ABB, 0, 2);
    waitResp("lw after rmw");
  endtask

  task automatic test_errors();
    int r0;
    int w0;
    r0 = rdCount;
    w0 = wrCount;
    issue(0, SIZE_HALF, 0, 32'h13, 32'h0, 32'h0, 1, 1);
    waitResp("lh misaligned");
    issue(0, SIZE_WORD, 0, 32'h06, 32'h0, 32'h0, 1, 1);
    waitResp("lw misaligned");
    issue(0, SIZE_ILLEGAL, 0, 32'h10, 32'h0, 32'h0, 1, 1);
    waitResp("size 3");
    issue(1, SIZE_BYTE, 0, 32'h203, 32'h77, 32'h0, 1, 1);
    waitResp("sb range");
    issue(0, SIZE_BYTE, 0, 32'h1FF, 32'h0, 32'h000000DE, 0, 2);
    waitResp("lbu top byte");
    tests++;
    if (rdCount - r0 != 1 || wrCount != w0) begin
      fails++;
      $display("FAIL error enables: reads %0d writes %0d required 1 0", rdCount - r0, wrCount - w0);
    end
  endtask

  task automatic test_reset_mid();
    issue(1, SIZE_BYTE, 0, 32'h10, 32'hFF, 32'h0, 0, 3);
    rq.reqValid = 1'b0;
    @(negedge clk);
    tests++;
    if (mb.memWrite !== 1'b1 || mb.memDataWrite !== 32'h12345AFF) begin
      fails++;
      $display("FAIL rmw_wr: memWrite=%b data=%h required 1 12345aff", mb.memWrite, mb.memDataWrite);
    end
    resetN = 1'b0;
    #1;
    tests++;
    if (mb.memWrite !== 1'b0 || rq.reqReady !== 1'b1) begin
      fails++;
      $display("FAIL async reset: memWrite=%b reqReady=%b required 0 1", mb.memWrite, rq.reqReady);
    end
    @(negedge clk);
    resetN = 1'b1;
    sb.delete();
    @(negedge clk);
    tests++;
    if (memArr[4] !== 32'h12345ABB) begin
      fails++;
      $display("FAIL abandoned write: word4=%h required 12345abb", memArr[4]);
    end
    tests++;
    if (rq.reqReady !== 1'b1 || rq.respValid !== 1'b0 || rq.respData !== 32'h0) begin
      fails++;
      $display("FAIL after reset: ready=%b valid=%b data=%h required 1 0 0", rq.reqReady, rq.respValid, rq.respData);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = accepts;
    issue(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h12345ABB, 0, 2);
    waitResp("b2b lw");
    issue(1, SIZE_WORD, 0, 32'h1FC, 32'h01020304, 32'h0, 0, 2);
    waitResp("b2b sw");
    issue(0, SIZE_WORD, 0, 32'h1FC, 32'h0, 32'h01020304, 0, 2);
    waitResp("b2b lw2");
    issue(1, SIZE_HALF, 0, 32'h1FE, 32'hBEEF, 32'h0, 0, 3);
    waitResp("b2b sh");
    issue(0, SIZE_WORD, 0, 32'h1FC, 32'h0, 32'hBEEF0304, 0, 2);
    waitResp("b2b lw3");
    rq.reqValid = 1'b0;
    @(negedge clk);
    tests++;
    if (accepts - a0 != 5 || sb.size() != 0) begin
      fails++;
      $display("FAIL b2b accepts: got %0d pending %0d required 5 0", accepts - a0, sb.size());
    end
  endtask

  initial begin
    rq.reqValid = 1'b0;
    rq.reqWrite = 1'b0;
    rq.reqSize = 2'd0;
    rq.reqSigned = 1'b0;
    rq.reqAddress = '0;
    rq.reqData = '0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  always @(negedge clk) begin
    if (mb.memRead && mb.memWrite) begin
      $display("FAIL enables: memRead=1 memWrite=1 required not both");
      $fatal(1);
    end
  end

  initial begin
    #50000;
    $display("FAIL global timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
